// File: rtl/jcs_demo_pkg.sv
// Shared definitions for the logic-gate demo board: mode encodings and
// the mode-index width rule used by the mode sequencer.
package jcs_demo_pkg;

    typedef enum logic [2:0] {
        NAND   = 3'd0,
        NOT    = 3'd1,
        AND    = 3'd2,
        OR     = 3'd3,
        XOR    = 3'd4,
        DEC3   = 3'd5,
        ENABLE = 3'd6,
        BUS1   = 3'd7
    } demo_mode_e;

    localparam int DEMO_MODES = 8;

    // Index width for a mode count; never narrower than one bit.
    function automatic int mode_width(input int nmodes);
        return (nmodes < 2) ? 1 : $clog2(nmodes);
    endfunction

endpackage

// File: rtl/jcs_debounce.sv
// Push-button front end: 2-flop synchroniser, counting debouncer and a
// registered rising-edge detector producing one click per press.
module jcs_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic BTN,
    output logic CLICK
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            CLICK   <= 1'b0;
        end else begin
            sync1   <= BTN;
            sync2   <= sync1;
            level_q <= level;
            CLICK   <= level & ~level_q;
            // Any cycle where the synchronised input agrees with the level restarts the run.
            if (sync2 != level) begin
                if (cnt == CLAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/jcs_mode_seq.sv
// Demo mode sequencer: steps the current mode on debounced PREV/NEXT clicks
// and, while AUTO_EN is high, auto-advances once every DWELL cycles.
module jcs_mode_seq
    import jcs_demo_pkg::*;
#(
    parameter int NMODES   = 8,
    parameter int WRAP     = 0,
    parameter int DEBOUNCE = 4,
    parameter int DWELL    = 100000000,
    parameter int MW       = mode_width(NMODES)
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          BTN_PREV,
    input  logic          BTN_NEXT,
    input  logic          AUTO_EN,
    output logic [MW-1:0] MODE,
    output logic          MODE_CHANGE,
    output logic          AUTO_ACTIVE
);

    localparam int DW = $clog2(DWELL);
    localparam logic [MW:0]   LAST  = (MW + 1)'(NMODES - 1);
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);

    logic          click_prev;
    logic          click_next;
    logic          auto_s1;
    logic          auto_s2;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] dwell_d;
    logic [MW-1:0] mode_d;
    logic          change_d;
    logic [MW:0]   mode_ext;
    logic          at_last;
    logic          at_first;
    logic          manual;
    logic          term;

    jcs_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_prev (
        .CLK    (CLK),
        .RESETN (RESETN),
        .BTN    (BTN_PREV),
        .CLICK  (click_prev)
    );

    jcs_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_next (
        .CLK    (CLK),
        .RESETN (RESETN),
        .BTN    (BTN_NEXT),
        .CLICK  (click_next)
    );

    always_comb begin
        mode_d   = MODE;
        change_d = 1'b0;
        dwell_d  = dwell_q + 1'b1;
        mode_ext = {1'b0, MODE};
        at_last  = (mode_ext == LAST);
        at_first = (MODE == '0);
        manual   = click_prev | click_next;
        term     = auto_s2 && (dwell_q == DLAST);

        // Manual clicks win over the auto step; a PREV+NEXT pair cancels outright.
        if (click_next && !click_prev) begin
            if (!at_last) begin
                mode_d   = MW'(mode_ext + 1'b1);
                change_d = 1'b1;
            end else if (WRAP != 0) begin
                mode_d   = '0;
                change_d = 1'b1;
            end
        end else if (click_prev && !click_next) begin
            if (!at_first) begin
                mode_d   = MW'(mode_ext - 1'b1);
                change_d = 1'b1;
            end else if (WRAP != 0) begin
                mode_d   = MW'(LAST);
                change_d = 1'b1;
            end
        end else if (!manual && term) begin
            mode_d   = at_last ? '0 : MW'(mode_ext + 1'b1);
            change_d = 1'b1;
        end

        if (!auto_s2 || manual || term) begin
            dwell_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            auto_s1     <= 1'b0;
            auto_s2     <= 1'b0;
            AUTO_ACTIVE <= 1'b0;
            dwell_q     <= '0;
            MODE        <= '0;
            MODE_CHANGE <= 1'b0;
        end else begin
            auto_s1     <= AUTO_EN;
            auto_s2     <= auto_s1;
            AUTO_ACTIVE <= auto_s2;
            dwell_q     <= dwell_d;
            MODE        <= mode_d;
            MODE_CHANGE <= change_d;
        end
    end

endmodule

// File: doc/jcs_mode_seq.md
JCS_MODE_SEQ -- requirements
Module: jcs_mode_seq

Interface
REQ-001 Parameter NMODES, default 8: number of demo modes; legal range 2..16.
REQ-002 Parameter WRAP, default 0: 1 = manual stepping wraps at the ends; 0 = manual stepping saturates.
REQ-003 Parameter DEBOUNCE, default 4: consecutive stable cycles required before a button level is accepted; minimum 1.
REQ-004 Parameter DWELL, default 100000000: clock cycles per auto-advance step; minimum 2.
REQ-005 Parameter MW, derived: ceil(log2(NMODES)); not overridden.
REQ-006 CLK  input  1  single system clock; all state changes on rising edge.
REQ-007 RESETN  input  1  reset, asynchronous, active-low.
REQ-008 BTN_PREV  input  1  raw asynchronous push button; a click steps to the previous mode.
REQ-009 BTN_NEXT  input  1  raw asynchronous push button; a click steps to the next mode.
REQ-010 AUTO_EN  input  1  level input; high enables timed auto-advance.
REQ-011 MODE  output  MW  current mode index; registered.
REQ-012 MODE_CHANGE  output  1  one-cycle pulse, high in the first cycle MODE holds a new value.
REQ-013 AUTO_ACTIVE  output  1  registered copy of the synchronised AUTO_EN.

Function
REQ-014 Each button SHALL pass through a 2-flop synchroniser, then a debouncer; the debounced level SHALL change only after the synchronised input has differed from it for DEBOUNCE consecutive cycles.
REQ-015 A click SHALL be a one-cycle pulse on each 0->1 transition of the debounced level; a 1->0 transition SHALL produce no pulse; a held button SHALL produce exactly one click.
REQ-016 Latency: a button high from edge k (clean input) SHALL produce its click in cycle k+2+DEBOUNCE, and MODE SHALL update at the following edge.
REQ-017 NEXT click: MODE<NMODES-1 -> MODE+1; MODE=NMODES-1 -> 0 if WRAP=1, else hold with no MODE_CHANGE.
REQ-018 PREV click: MODE>0 -> MODE-1; MODE=0 -> NMODES-1 if WRAP=1, else hold with no MODE_CHANGE.
REQ-019 Simultaneous PREV and NEXT clicks in the same cycle SHALL cancel: MODE held, no MODE_CHANGE.
REQ-020 AUTO_EN SHALL be synchronised by 2 flops; while synchronised AUTO_EN is high, a dwell counter SHALL count 0..DWELL-1; the terminal count SHALL advance MODE as a NEXT click that always wraps, regardless of WRAP, and return the counter to 0.
REQ-021 Any manual click, whether or not it changes MODE, SHALL clear the dwell counter; a manual click coinciding with the terminal count SHALL take precedence, and the auto step SHALL be dropped.
REQ-022 Synchronised AUTO_EN low SHALL hold the dwell counter at 0; re-enabling SHALL wait a full DWELL cycles before the first auto step.
REQ-023 MODE SHALL never hold a value >= NMODES.
REQ-024 MODE_CHANGE SHALL assert exactly once per MODE update and at no other time.

Reset
REQ-025 RESETN low SHALL asynchronously force: MODE=0, MODE_CHANGE=0, AUTO_ACTIVE=0, dwell counter=0, synchroniser flops=0, debounced levels=0, debounce counters=0.
REQ-026 Reset asserted mid-debounce or mid-dwell SHALL discard partial counts; a button held through reset release SHALL produce one click after 2+DEBOUNCE cycles.
REQ-027 Release of RESETN is synchronised externally; no click or MODE_CHANGE SHALL occur in the first cycle after release unless a button was already stably high.

Structure
REQ-028 Demo mode encodings (NAND=0, NOT, AND, OR, XOR, DEC3, ENABLE, BUS1=7) and the MW width rule SHALL live in the shared package jcs_demo_pkg.
REQ-029 Synchroniser, debouncer and edge detector SHALL form one sub-module, jcs_debounce (parameter DEBOUNCE), instantiated once per button.
REQ-030 The dwell counter width SHALL be ceil(log2(DWELL)); no other arithmetic SHALL be wider than MW+1.

Verification (NMODES=8, DEBOUNCE=4, DWELL=20 unless stated)
REQ-031 Reset, then BTN_NEXT high for 10 cycles -> MODE 0->1 at cycle 7, single MODE_CHANGE pulse, no second step while held.
REQ-032 BTN_NEXT toggling every cycle for 30 cycles -> no click, MODE stays 0.
REQ-033 WRAP=0: MODE=7 + NEXT -> stays 7, no pulse; MODE=0 + PREV -> stays 0. WRAP=1: 7+NEXT -> 0; 0+PREV -> 7.
REQ-034 PREV and NEXT pressed on the same edge -> MODE unchanged, no MODE_CHANGE.
REQ-035 AUTO_EN=1 from MODE=6 -> steps to 7 then 0 at 20-cycle intervals after sync; a NEXT click at the terminal count -> exactly one step, and the counter restarts.
REQ-036 RESETN low mid-dwell with MODE=5 -> MODE=0 immediately, without a clock edge; after release, the first auto step occurs a full 20 cycles later.
